// File: rtl/spike_stim_sequencer.sv
// Stimulus/response sequencer for the 3-in/2-out spiking network: stores spike
// patterns, plays them MSB first onto n1..n3 and reports per-pattern n7/n8 spike counts.
module spike_stim_sequencer #(
    parameter  int PAT_LEN   = 40,
    parameter  int NUM_PAT   = 4,
    parameter  int IDX_W     = 2,
    parameter  int DRAIN_CYC = 2,
    localparam int CNT_W     = $clog2(PAT_LEN + DRAIN_CYC + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [1:0]         cfg_ch,
    input  logic [PAT_LEN-1:0] cfg_data,
    input  logic               start,
    input  logic               run_all,
    input  logic [IDX_W-1:0]   pat_sel,
    input  logic               abort,
    input  logic               n7,
    input  logic               n8,
    output logic               n1,
    output logic               n2,
    output logic               n3,
    output logic               busy,
    output logic               res_valid,
    output logic [IDX_W-1:0]   res_idx,
    output logic [CNT_W-1:0]   res_n7_cnt,
    output logic [CNT_W-1:0]   res_n8_cnt,
    output logic               done
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DRAIN, S_REPORT} state_t;

    state_t             state_q, state_d;
    logic [PAT_LEN-1:0] mem_q [NUM_PAT][3];
    logic [PAT_LEN-1:0] sh_q [3];
    logic [PAT_LEN-1:0] sh_d [3];
    logic [PAT_LEN-1:0] pat_load [3];
    logic [2:0]         n_q, n_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   cnt7_q, cnt7_d, cnt8_q, cnt8_d;
    logic [CNT_W-1:0]   cnt7_inc, cnt8_inc;
    logic [IDX_W-1:0]   slot_q, slot_d, load_slot;
    logic               run_all_q, run_all_d;
    logic [IDX_W-1:0]   res_idx_q, res_idx_d;
    logic [CNT_W-1:0]   res7_q, res7_d, res8_q, res8_d;
    logic               wr_en, more, load, to_report;

    assign wr_en    = cfg_we && (state_q == S_IDLE) && (cfg_ch != 2'd3);
    assign more     = run_all_q && (slot_q != IDX_W'(NUM_PAT - 1));
    assign cnt7_inc = cnt7_q + CNT_W'(n7);
    assign cnt8_inc = cnt8_q + CNT_W'(n8);

    always_comb begin
        if (state_q == S_REPORT) begin
            load_slot = slot_q + IDX_W'(1);
        end else begin
            load_slot = run_all ? '0 : pat_sel;
        end
    end

    // A write landing on the same edge as start must be seen by the playback.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_fwd
            assign pat_load[gi] = (wr_en && cfg_idx == load_slot && cfg_ch == 2'(gi))
                                  ? cfg_data : mem_q[load_slot][gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_PAT; s++) begin
                for (int c = 0; c < 3; c++) begin
                    mem_q[s][c] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[cfg_idx][cfg_ch] <= cfg_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        n_d       = '0;
        cyc_d     = cyc_q;
        cnt7_d    = cnt7_q;
        cnt8_d    = cnt8_q;
        slot_d    = slot_q;
        run_all_d = run_all_q;
        res_idx_d = res_idx_q;
        res7_d    = res7_q;
        res8_d    = res8_q;
        load      = 1'b0;
        to_report = 1'b0;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        load      = 1'b1;
                        run_all_d = run_all;
                        slot_d    = load_slot;
                    end
                end
                S_PLAY: begin
                    cnt7_d = cnt7_inc;
                    cnt8_d = cnt8_inc;
                    cyc_d  = cyc_q + CNT_W'(1);
                    if (cyc_q == CNT_W'(PAT_LEN - 1)) begin
                        if (DRAIN_CYC == 0) begin
                            to_report = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        for (int c = 0; c < 3; c++) begin
                            n_d[c]  = sh_q[c][PAT_LEN-1];
                            sh_d[c] = sh_q[c] << 1;
                        end
                    end
                end
                S_DRAIN: begin
                    cnt7_d = cnt7_inc;
                    cnt8_d = cnt8_inc;
                    cyc_d  = cyc_q + CNT_W'(1);
                    if (cyc_q == CNT_W'(PAT_LEN + DRAIN_CYC - 1)) begin
                        to_report = 1'b1;
                    end
                end
                S_REPORT: begin
                    if (more) begin
                        load   = 1'b1;
                        slot_d = load_slot;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            // Results include the count from the cycle that ends on this edge.
            if (to_report) begin
                state_d   = S_REPORT;
                res_idx_d = slot_q;
                res7_d    = cnt7_inc;
                res8_d    = cnt8_inc;
            end
            if (load) begin
                state_d = S_PLAY;
                cyc_d   = '0;
                cnt7_d  = '0;
                cnt8_d  = '0;
                for (int c = 0; c < 3; c++) begin
                    n_d[c]  = pat_load[c][PAT_LEN-1];
                    sh_d[c] = pat_load[c] << 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            cyc_q     <= '0;
            cnt7_q    <= '0;
            cnt8_q    <= '0;
            slot_q    <= '0;
            run_all_q <= 1'b0;
            res_idx_q <= '0;
            res7_q    <= '0;
            res8_q    <= '0;
            for (int c = 0; c < 3; c++) begin
                sh_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cyc_q     <= cyc_d;
            cnt7_q    <= cnt7_d;
            cnt8_q    <= cnt8_d;
            slot_q    <= slot_d;
            run_all_q <= run_all_d;
            res_idx_q <= res_idx_d;
            res7_q    <= res7_d;
            res8_q    <= res8_d;
            sh_q      <= sh_d;
        end
    end

    assign n1         = n_q[0];
    assign n2         = n_q[1];
    assign n3         = n_q[2];
    assign busy       = (state_q != S_IDLE);
    assign res_valid  = (state_q == S_REPORT);
    assign done       = res_valid && !more;
    assign res_idx    = res_idx_q;
    assign res_n7_cnt = res7_q;
    assign res_n8_cnt = res8_q;

endmodule

// File: tb/tb_spike_stim_sequencer.sv
// Randomized bench for spike_stim_sequencer with n7=n1 / n8=n2 loopback; expected
// bit streams and spike counts come from a pattern-level memory model.
module tb_spike_stim_sequencer;
    localparam int PAT_LEN = 40;
    localparam int NUM_PAT = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 6;
    localparam int PERIOD  = 43;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [1:0]         cfg_ch;
    logic [PAT_LEN-1:0] cfg_data;
    logic               start;
    logic               run_all;
    logic [IDX_W-1:0]   pat_sel;
    logic               abort;
    logic               n7, n8;
    logic               n1, n2, n3;
    logic               busy, res_valid, done;
    logic [IDX_W-1:0]   res_idx;
    logic [CNT_W-1:0]   res_n7_cnt, res_n8_cnt;
    logic               force7;

    logic [PAT_LEN-1:0] model_mem [NUM_PAT][3];
    int n_pass  = 0;
    int n_total = 0;

    assign n7 = n1 | force7;
    assign n8 = n2;

    always #5 clk = ~clk;

    spike_stim_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_ch     (cfg_ch),
        .cfg_data   (cfg_data),
        .start      (start),
        .run_all    (run_all),
        .pat_sel    (pat_sel),
        .abort      (abort),
        .n7         (n7),
        .n8         (n8),
        .n1         (n1),
        .n2         (n2),
        .n3         (n3),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_idx    (res_idx),
        .res_n7_cnt (res_n7_cnt),
        .res_n8_cnt (res_n8_cnt),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int s = 0; s < NUM_PAT; s++)
            for (int c = 0; c < 3; c++)
                model_mem[s][c] = '0;
    endtask

    function automatic logic [PAT_LEN-1:0] rand_pat();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[PAT_LEN-1:0];
    endfunction

    task automatic write_cfg(input int idx, input int ch, input logic [PAT_LEN-1:0] data);
        cfg_we   = 1'b1;
        cfg_idx  = IDX_W'(idx);
        cfg_ch   = 2'(ch);
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
        if (ch < 3) model_mem[idx][ch] = data;
    endtask

    // Plays one slot (or all) and checks every stimulus bit and each report.
    // p_inj >= 0 pulses start and a write in that PLAY cycle; both must be ignored.
    task automatic run_play(input bit p_all, input int p_sel, input int p_inj);
        int first, last, errs, e7, e8;
        first   = p_all ? 0 : p_sel;
        last    = p_all ? NUM_PAT - 1 : p_sel;
        start   = 1'b1;
        run_all = p_all;
        pat_sel = IDX_W'(p_sel);
        tick();
        cfg_we  = 1'b0;
        start   = 1'b0;
        run_all = 1'($urandom);
        pat_sel = IDX_W'($urandom);
        e7 = 0;
        for (int s = first; s <= last; s++) begin
            errs = 0;
            for (int k = 0; k < PAT_LEN; k++) begin
                if (n1 !== model_mem[s][0][PAT_LEN-1-k]) errs++;
                if (n2 !== model_mem[s][1][PAT_LEN-1-k]) errs++;
                if (n3 !== model_mem[s][2][PAT_LEN-1-k]) errs++;
                if (busy !== 1'b1 || res_valid !== 1'b0 || done !== 1'b0) errs++;
                if (k == p_inj) begin
                    start    = 1'b1;
                    run_all  = ~p_all;
                    pat_sel  = IDX_W'(s + 1);
                    cfg_we   = 1'b1;
                    cfg_idx  = IDX_W'(s);
                    cfg_ch   = 2'd0;
                    cfg_data = ~model_mem[s][0];
                end
                tick();
                start  = 1'b0;
                cfg_we = 1'b0;
            end
            for (int d = 0; d < 2; d++) begin
                if ({n1, n2, n3} !== 3'b000 || busy !== 1'b1 || res_valid !== 1'b0) errs++;
                tick();
            end
            e7 = force7 ? (PAT_LEN + 2) : $countones(model_mem[s][0]);
            e8 = $countones(model_mem[s][1]);
            n_total++;
            if (errs != 0) $display("FAIL stim slot %0d: got %0d bad cycles, expected 0", s, errs);
            else n_pass++;
            n_total++;
            if (res_valid !== 1'b1 || {n1, n2, n3} !== 3'b000)
                $display("FAIL res_valid slot %0d: got %0b expected 1", s, res_valid);
            else n_pass++;
            n_total++;
            if (res_idx !== IDX_W'(s)) $display("FAIL res_idx: got %0d expected %0d", res_idx, s);
            else n_pass++;
            n_total++;
            if (res_n7_cnt !== CNT_W'(e7)) $display("FAIL n7_cnt slot %0d: got %0d expected %0d", s, res_n7_cnt, e7);
            else n_pass++;
            n_total++;
            if (res_n8_cnt !== CNT_W'(e8)) $display("FAIL n8_cnt slot %0d: got %0d expected %0d", s, res_n8_cnt, e8);
            else n_pass++;
            n_total++;
            if (done !== (s == last)) $display("FAIL done slot %0d: got %0b expected %0b", s, done, s == last);
            else n_pass++;
            $display("result slot %0d: n7=%0d n8=%0d done=%0b", res_idx, res_n7_cnt, res_n8_cnt, done);
            tick();
        end
        n_total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0 || res_n7_cnt !== CNT_W'(e7))
            $display("FAIL idle_after: got busy=%0b valid=%0b n7=%0d expected 0/0/%0d",
                     busy, res_valid, res_n7_cnt, e7);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++;
        if ({busy, n1, n2, n3, res_valid, done} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000", {busy, n1, n2, n3, res_valid, done});
        else n_pass++;
        n_total++;
        if ({res_idx, res_n7_cnt, res_n8_cnt} !== '0)
            $display("FAIL reset_res: got %0d/%0d/%0d expected 0/0/0", res_idx, res_n7_cnt, res_n8_cnt);
        else n_pass++;
        rst = 1'b0;
        clear_model();
        tick();
        $display("reset done");
    endtask

    task automatic test_idle_zero();
        run_play(1'b0, 0, -1);
    endtask

    task automatic test_bit_order();
        write_cfg(1, 0, 40'h8000000001);
        run_play(1'b0, 1, -1);
    endtask

    task automatic test_run_all();
        for (int s = 0; s < NUM_PAT; s++) begin
            write_cfg(s, 0, 40'hAAAAAAAAAA);
            write_cfg(s, 1, 40'h5555555555);
            write_cfg(s, 2, rand_pat());
        end
        run_play(1'b1, int'($urandom_range(0, NUM_PAT - 1)), -1);
    endtask

    task automatic test_random();
        int sel, ch;
        for (int it = 0; it < 4; it++) begin
            for (int w = 0; w < 4; w++)
                write_cfg(int'($urandom_range(0, NUM_PAT - 1)), int'($urandom_range(0, 3)), rand_pat());
            sel = int'($urandom_range(0, NUM_PAT - 1));
            ch  = int'($urandom_range(0, 2));
            cfg_we   = 1'b1;
            cfg_idx  = IDX_W'(sel);
            cfg_ch   = 2'(ch);
            cfg_data = rand_pat();
            model_mem[sel][ch] = cfg_data;
            run_play(1'b0, sel, -1);
        end
    endtask

    task automatic test_n7_const();
        force7 = 1'b1;
        run_play(1'b0, int'($urandom_range(0, NUM_PAT - 1)), -1);
        force7 = 1'b0;
    endtask

    task automatic test_busy_ignore();
        int sel;
        sel = int'($urandom_range(0, NUM_PAT - 1));
        write_cfg(sel, 0, rand_pat() | 40'h1);
        run_play(1'b0, sel, 10);
        run_play(1'b0, sel, -1);
        write_cfg(sel, 3, rand_pat());
        run_play(1'b0, sel, -1);
    endtask

    task automatic test_stop(input bit use_rst);
        int sel, errs;
        sel = int'($urandom_range(0, NUM_PAT - 1));
        write_cfg(sel, 0, rand_pat() | 40'h8000000001);
        write_cfg(sel, 1, rand_pat() | 40'h1);
        start   = 1'b1;
        run_all = 1'b0;
        pat_sel = IDX_W'(sel);
        tick();
        start = 1'b0;
        for (int k = 1; k < 15; k++) tick();
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
        tick();
        rst   = 1'b0;
        abort = 1'b0;
        n_total++;
        if ({busy, n1, n2, n3, res_valid, done} !== 6'b0)
            $display("FAIL stop_%0d: got %b expected 000000", use_rst, {busy, n1, n2, n3, res_valid, done});
        else n_pass++;
        errs = 0;
        for (int k = 0; k < PERIOD + 5; k++) begin
            if ({busy, n1, n2, n3, res_valid, done} !== 6'b0) errs++;
            tick();
        end
        n_total++;
        if (errs != 0) $display("FAIL stop_quiet_%0d: got %0d active cycles expected 0", use_rst, errs);
        else n_pass++;
        $display("stopped slot %0d via %s", sel, use_rst ? "rst" : "abort");
        if (use_rst) clear_model();
        run_play(1'b0, sel, -1);
    endtask

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_ch = '0; cfg_data = '0;
        start = 1'b0; run_all = 1'b0; pat_sel = '0; abort = 1'b0; force7 = 1'b0;
        test_reset();
        test_idle_zero();
        test_bit_order();
        test_run_all();
        test_random();
        test_n7_const();
        test_busy_ignore();
        test_stop(1'b0);
        test_stop(1'b1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
